// File: rtl/z16_instr_loader.sv
// Boot-time loader for the Z16 instruction memory: turns a count/words/checksum
// byte stream into little-endian 16-bit writes and holds the CPU until a clean load.
module z16_instr_loader #(
  parameter int DEPTH = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_hold
);

  localparam int IW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [7:0]  chk_reg, chk_next;
  logic [7:0]  lo_reg, lo_next;
  logic [15:0] waddr_reg, waddr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] idx_inc;

  assign xfer     = i_rx_valid && o_rx_ready;
  assign len_full = {i_rx_data, cnt_reg[7:0]};
  assign idx_inc  = {{(16-IW){1'b0}}, idx_reg} + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      chk_reg   <= '0;
      lo_reg    <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      chk_reg   <= chk_next;
      lo_reg    <= lo_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    chk_next   = chk_reg;
    lo_next    = lo_reg;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    o_rx_ready = 1'b0;
    o_we       = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_next = S_LEN_LO;
          idx_next   = '0;
          chk_next   = '0;
        end
      end
      S_LEN_LO: begin
        o_rx_ready = 1'b1;
        if (xfer) begin
          cnt_next   = {cnt_reg[15:8], i_rx_data};
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        o_rx_ready = 1'b1;
        if (xfer) begin
          cnt_next = len_full;
          if (len_full > 16'(DEPTH))
            state_next = S_ERR;
          else if (len_full == 16'd0)
            state_next = S_CHK;
          else
            state_next = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        o_rx_ready = 1'b1;
        if (xfer) begin
          lo_next    = i_rx_data;
          chk_next   = chk_reg ^ i_rx_data;
          state_next = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        o_rx_ready = 1'b1;
        if (xfer) begin
          // Address/data are latched here so they are valid during WRITE and
          // then simply hold until the next word.
          chk_next   = chk_reg ^ i_rx_data;
          waddr_next = {{(15-IW){1'b0}}, idx_reg, 1'b0};
          wdata_next = {i_rx_data, lo_reg};
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_we     = 1'b1;
        idx_next = idx_reg + 1'b1;
        state_next = (idx_inc == cnt_reg) ? S_CHK : S_DAT_LO;
      end
      S_CHK: begin
        o_rx_ready = 1'b1;
        if (xfer)
          state_next = (i_rx_data == chk_reg) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_waddr    = waddr_reg;
  assign o_wdata    = wdata_reg;
  assign o_busy     = !(state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
  assign o_done     = (state_reg == S_DONE);
  assign o_err      = (state_reg == S_ERR);
  assign o_cpu_hold = (state_reg != S_DONE);

endmodule

// File: tb/tb_z16_instr_loader.sv
// Directed bench for z16_instr_loader: table of byte streams with expected writes
// and final status, plus hand sequences for reset and mid-load reset.
module tb_z16_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  always #5 clk = ~clk;

  z16_instr_loader #(.DEPTH(11)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_we       (we),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_cpu_hold (cpu_hold)
  );

  typedef struct packed {
    logic [7:0]        nbytes;
    logic [32*8-1:0]   bytes;
    logic              toggle;
    logic [3:0]        nwr;
    logic [12*16-1:0]  wdat;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int failures = 0;
  logic [31:0] wq[$];

  // Every write strobe cycle is recorded once, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) if (we) wq.push_back({waddr, wdata});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic put(input int v, input int i, input logic [7:0] b);
    vecs[v].bytes[i*8 +: 8] = b;
  endtask

  task automatic putw(input int v, input int k, input logic [15:0] w);
    vecs[v].wdat[k*16 +: 16] = w;
  endtask

  // Three-word program 0040/0050/0080; the XOR of its data bytes is 0x90.
  task automatic mk_std(input int v, input logic [7:0] chk, input logic tog,
                        input logic d, input logic e);
    vecs[v] = '0;
    vecs[v].nbytes = 8'd9;
    put(v, 0, 8'h03); put(v, 1, 8'h00);
    put(v, 2, 8'h40); put(v, 3, 8'h00);
    put(v, 4, 8'h50); put(v, 5, 8'h00);
    put(v, 6, 8'h80); put(v, 7, 8'h00);
    put(v, 8, chk);
    vecs[v].toggle = tog;
    vecs[v].nwr = 4'd3;
    putw(v, 0, 16'h0040); putw(v, 1, 16'h0050); putw(v, 2, 16'h0080);
    vecs[v].exp_done = d;
    vecs[v].exp_err  = e;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic drive(input int v);
    int i;
    int cyc;
    logic rdy;
    logic [32*8-1:0] b;
    i = 0;
    cyc = 0;
    b = vecs[v].bytes;
    while (i < int'(vecs[v].nbytes) && cyc < 1000) begin
      rx_data  = b[i*8 +: 8];
      rx_valid = vecs[v].toggle ? (cyc % 2 == 0) : 1'b1;
      #1 rdy = rx_ready;
      @(posedge clk);
      if (rx_valid && rdy) i++;
      cyc++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check($sformatf("v%0d bytes_accepted", v), i, vecs[v].nbytes);
  endtask

  task automatic run_vec(input int v);
    int n;
    logic [12*16-1:0] w;
    wq.delete();
    pulse_start();
    drive(v);
    w = vecs[v].wdat;
    n = vecs[v].nwr;
    check($sformatf("v%0d done", v), done, vecs[v].exp_done);
    check($sformatf("v%0d err", v), err, vecs[v].exp_err);
    check($sformatf("v%0d cpu_hold", v), cpu_hold, !vecs[v].exp_done);
    check($sformatf("v%0d busy", v), busy, 1'b0);
    check($sformatf("v%0d rx_ready", v), rx_ready, 1'b0);
    check($sformatf("v%0d write_count", v), wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++)
      check($sformatf("v%0d write%0d", v, k), wq[k], {16'(2*k), w[k*16 +: 16]});
    if (n > 0) begin
      check($sformatf("v%0d waddr_hold", v), waddr, 16'(2*(n-1)));
      check($sformatf("v%0d wdata_hold", v), wdata, w[(n-1)*16 +: 16]);
    end
    $display("vec %0d: bytes=%0d writes=%0d done=%0b err=%0b hold=%0b",
             v, vecs[v].nbytes, wq.size(), done, err, cpu_hold);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_ready"}, rx_ready, 1'b0);
    check({tag, " we"}, we, 1'b0);
    check({tag, " waddr"}, waddr, 16'h0000);
    check({tag, " wdata"}, wdata, 16'h0000);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " err"}, err, 1'b0);
    check({tag, " cpu_hold"}, cpu_hold, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;

    mk_std(0, 8'h90, 1'b0, 1'b1, 1'b0);
    mk_std(1, 8'hD0, 1'b0, 1'b0, 1'b1);
    mk_std(2, 8'hFF, 1'b0, 1'b0, 1'b1);
    mk_std(3, 8'h90, 1'b1, 1'b1, 1'b0);
    vecs[4] = '0; vecs[4].nbytes = 8'd3; vecs[4].exp_done = 1'b1;
    vecs[5] = '0; vecs[5].nbytes = 8'd2; put(5, 0, 8'h0C); vecs[5].exp_err = 1'b1;
    vecs[6] = '0; vecs[6].nbytes = 8'd2; put(6, 1, 8'h01); vecs[6].exp_err = 1'b1;
    vecs[7] = '0; vecs[7].nbytes = 8'd5; vecs[7].nwr = 4'd1; vecs[7].exp_done = 1'b1;
    put(7, 0, 8'h01); put(7, 2, 8'h34); put(7, 3, 8'h12); put(7, 4, 8'h26);
    putw(7, 0, 16'h1234);
    // Full-depth program: words 10nn with nn=1..11; XOR of all data bytes is 0x10.
    vecs[8] = '0; vecs[8].nbytes = 8'd25; vecs[8].nwr = 4'd11; vecs[8].exp_done = 1'b1;
    put(8, 0, 8'h0B);
    for (int k = 0; k < 11; k++) begin
      put(8, 2 + 2*k, 8'(k + 1));
      put(8, 3 + 2*k, 8'h10);
      putw(8, k, {8'h10, 8'(k + 1)});
    end
    put(8, 24, 8'h10);
    vecs[9] = vecs[0]; vecs[9].nbytes = 8'd4;

    repeat (3) @(negedge clk);
    check_reset("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");
    $display("reset: hold=%0b busy=%0b", cpu_hold, busy);

    for (int v = 0; v < 9; v++) run_vec(v);

    // Reset arriving after the second data byte abandons the load.
    pulse_start();
    drive(9);
    check("midload busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midload_reset");
    $display("midload reset: done=%0b hold=%0b waddr=%h", done, cpu_hold, waddr);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
